goertzel_detector: RTL and testbench
====================================

Name: goertzel_detector

Overview:
- Tone detector: the receive end for the sineGen resonator output.
- Runs a Goertzel recurrence over blocks of N signed samples and reports one power value per block at a programmable bin frequency.
- Asserts a detect flag when the power reaches a threshold.
- Sits after the sample source (resonator or ADC front end) and feeds control/status logic.

Parameters:
- DATA_W, 8, sample width (signed two's complement)
- N, 205, samples per block (>=2)
- ACC_W, 24, width of the signed Goertzel state registers s1/s2
- COEFF_W, 16, width of coeff; signed Q2.14 format
- PWR_W, 48, width of power output (2*ACC_W)

Ports:
- clk, in, 1, rising-edge clock
- reset, in, 1, synchronous active-high reset
- in, in, DATA_W, signed input sample
- in_valid, in, 1, sample strobe
- in_ready, out, 1, high when a sample can be accepted
- coeff, in, COEFF_W, 2*cos(2*pi*k/N) in Q2.14, signed
- thresh, in, PWR_W, unsigned detect threshold
- power, out, PWR_W, unsigned block power, held until the next result
- power_valid, out, 1, one-cycle pulse when power updates
- detect, out, 1, (power >= thresh), held with power

Behaviour:
- Reset values (at the clk edge with reset=1): power=0, power_valid=0, detect=0, s1=s2=0, count=0, state=ACCUM, in_ready=1. Reset has priority over all other inputs and aborts any block in progress.
- States:
  - ACCUM: in_ready=1. A sample is accepted on a clk edge with in_valid=1.
  - C1, C2, C3: in_ready=0. in_valid is ignored; those samples are dropped and not counted.
- coeff handling: latched into c_reg when the first sample of a block is accepted (count==0). coeff changes mid-block have no effect.
- Accept: s = in + ((c*s1) >>> 14) - s2. c is c_reg, or coeff directly on the first sample.
  - Arithmetic is full precision; the result saturates to the signed ACC_W range.
  - Then s2 <= s1, s1 <= s, count <= count+1.
- Block end: on the accept with count==N-1, go to C1 and clear count.
- Power computation, one cycle per state, products are full-width signed:
  - C1: t <= (c_reg*s1) >>> 14.
  - C2: a <= s1*s1 + s2*s2.
  - C3: p = a - t*s2. Negative p clamps to 0; p saturates at 2^PWR_W-1. Register power <= p, detect <= (p >= thresh), power_valid <= 1. Clear s1=s2=0. Go to ACCUM.
- Latency: with the Nth sample accepted at edge k, power, detect and power_valid update at edge k+3. power_valid is high for exactly one cycle. The first sample of the next block can be accepted at edge k+4.
- power_valid is 0 in every cycle other than the one following C3.
- thresh is sampled in C3 only.
- Reset asserted during C1–C3: no power_valid pulse is produced, and power/detect return to 0.
- Back-to-back blocks have no gap except the 3 compute cycles.

Decomposition:
- Shared package goertzel_pkg:
  - state encoding (ACCUM, C1, C2, C3)
  - Q-format shift constant (14)
  - saturation helper function
- One natural sub-module: goertzel_sat. Parameterised signed saturating truncation from a wide width to an output width; used for the s update and the power clamp.

Test Plan:
- N=4, coeff=0, in = 1,0,-1,0 with in_valid high every cycle -> s1/s2 after each accept = (1,0),(0,1),(-2,0),(0,-2). Then power=4 and power_valid pulses once, 3 edges after the 4th accept. detect=1 with thresh=4 and detect=0 with thresh=5.
- N=4, coeff=0, in = 1,1,1,1 -> power=0, detect=0 with thresh=1 (DC rejected).
- in_valid held high during C1–C3 -> in_ready=0, those samples are dropped. The next block's first sample is accepted at edge k+4, and a following 1,0,-1,0 block again yields power=4.
- Reset pulsed after 2 accepted samples, then 1,0,-1,0 -> power=4 for the post-reset block. No power_valid pulse occurs between reset and that block's result.
- ACC_W=12, N=64, coeff=32767, in=127 constant -> s1 saturates at 2047 and never wraps negative. power is clamped and non-negative, and power_valid pulses once.
- coeff changed from 0 to 16384 after the first sample of a block -> result is identical to a run with coeff held at 0.

Source files
------------

// File: rtl/goertzel_pkg.sv
// goertzel_pkg
//   Shared definitions for the Goertzel tone detector:
//   - FSM state encoding (accumulate, then three power-compute cycles)
//   - Q-format shift for the Q2.14 coefficient
//   - signed saturation helper used by goertzel_sat
//   No ports; imported by goertzel_sat and goertzel_detector.
package goertzel_pkg;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_C1    = 2'd1;
  localparam logic [1:0] ST_C2    = 2'd2;
  localparam logic [1:0] ST_C3    = 2'd3;

  // coeff is Q2.14, so a product with it carries 14 fractional bits
  localparam int Q_SHIFT = 14;

  // Widest value the saturation helper handles; callers sign-extend into it
  localparam int SAT_MAX_W = 128;

  // Clamp a signed value to the signed range of a w-bit number
  // (w < SAT_MAX_W). The result is returned at full helper width.
  function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
    input logic signed [SAT_MAX_W-1:0] x,
    input int                          w
  );
    logic signed [SAT_MAX_W-1:0] one;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    one = SAT_MAX_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/goertzel_sat.sv
// goertzel_sat
//   Signed saturating truncation from IN_W bits down to OUT_W bits.
//   Values outside the OUT_W signed range clamp to its min/max instead
//   of wrapping.
// Ports:
//   din  - signed IN_W-bit input
//   dout - signed OUT_W-bit saturated output
module goertzel_sat #(
  parameter int IN_W  = 42,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  import goertzel_pkg::*;

  logic signed [SAT_MAX_W-1:0] wide_in;
  logic signed [SAT_MAX_W-1:0] wide_out;
  logic                        unused_hi;

  // Sign-extend into the helper width, clamp, then keep the low OUT_W bits,
  // which after clamping carry the whole value.
  assign wide_in   = SAT_MAX_W'(din);
  assign wide_out  = sat_signed(wide_in, OUT_W);
  assign dout      = wide_out[OUT_W-1:0];
  assign unused_hi = ^wide_out[SAT_MAX_W-1:OUT_W];

endmodule

// File: rtl/goertzel_detector.sv
// goertzel_detector
//   Block Goertzel tone detector. Accumulates N signed samples through the
//   recurrence s = in + c*s1 - s2 (c in Q2.14), then spends three cycles
//   computing power = s1^2 + s2^2 - c*s1*s2 and compares it to a threshold.
// Ports:
//   clk         - rising-edge clock
//   reset       - synchronous active-high reset, aborts any block
//   in          - signed DATA_W-bit sample
//   in_valid    - sample strobe
//   in_ready    - high while samples are accepted (accumulate state)
//   coeff       - 2*cos(2*pi*k/N), signed Q2.14, latched on a block's 1st sample
//   thresh      - unsigned detect threshold, sampled on the final compute cycle
//   power       - unsigned block power, held until the next result
//   power_valid - one-cycle pulse when power updates
//   detect      - power >= thresh, held with power
module goertzel_detector #(
  parameter int DATA_W  = 8,
  parameter int N       = 205,
  parameter int ACC_W   = 24,
  parameter int COEFF_W = 16,
  parameter int PWR_W   = 48
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [DATA_W-1:0]  in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEFF_W-1:0] coeff,
  input  logic [PWR_W-1:0]          thresh,
  output logic [PWR_W-1:0]          power,
  output logic                      power_valid,
  output logic                      detect
);
  import goertzel_pkg::*;

  localparam int CNT_W  = (N > 2) ? $clog2(N) : 1;
  localparam int PROD_W = COEFF_W + ACC_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int SQ_W   = 2 * ACC_W;
  localparam int A_W    = SQ_W + 1;
  localparam int TS_W   = PROD_W + ACC_W;
  localparam int P_W    = TS_W + 2;

  logic [1:0]                state;
  logic [CNT_W-1:0]          count;
  logic signed [ACC_W-1:0]   s1;
  logic signed [ACC_W-1:0]   s2;
  logic signed [COEFF_W-1:0] c_reg;
  logic signed [PROD_W-1:0]  t;
  logic signed [A_W-1:0]     a;

  logic                      accept;
  logic signed [COEFF_W-1:0] c_mult;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  prod_q;
  logic signed [SUM_W-1:0]   s_wide;
  logic signed [ACC_W-1:0]   s_next;
  logic signed [SQ_W-1:0]    sq1;
  logic signed [SQ_W-1:0]    sq2;
  logic signed [A_W-1:0]     a_next;
  logic signed [TS_W-1:0]    ts;
  logic signed [P_W-1:0]     p_wide;
  logic signed [PWR_W:0]     p_sat;
  logic [PWR_W-1:0]          p_clamped;

  assign in_ready = (state == ST_ACCUM);
  assign accept   = in_ready && in_valid;

  // One c*s1 multiplier serves both the recurrence and the C1 step. On the
  // first sample of a block c_reg is not loaded yet, so coeff is used live.
  assign c_mult = ((state == ST_ACCUM) && (count == '0)) ? coeff : c_reg;
  assign prod   = PROD_W'(c_mult) * PROD_W'(s1);
  assign prod_q = prod >>> Q_SHIFT;

  // Recurrence at full precision, then clamp into the state register range
  assign s_wide = SUM_W'(in) + SUM_W'(prod_q) - SUM_W'(s2);

  goertzel_sat #(
    .IN_W  (SUM_W),
    .OUT_W (ACC_W)
  ) u_sat_s (
    .din  (s_wide),
    .dout (s_next)
  );

  // Power terms: a = s1^2 + s2^2, p = a - t*s2 with t = (c*s1) >>> 14
  assign sq1    = SQ_W'(s1) * SQ_W'(s1);
  assign sq2    = SQ_W'(s2) * SQ_W'(s2);
  assign a_next = A_W'(sq1) + A_W'(sq2);
  assign ts     = TS_W'(t) * TS_W'(s2);
  assign p_wide = P_W'(a) - P_W'(ts);

  // Saturating to PWR_W+1 signed bits caps the top at 2^PWR_W-1; a negative
  // result (possible from truncation in t) is then forced to zero.
  goertzel_sat #(
    .IN_W  (P_W),
    .OUT_W (PWR_W + 1)
  ) u_sat_p (
    .din  (p_wide),
    .dout (p_sat)
  );

  assign p_clamped = p_sat[PWR_W] ? '0 : p_sat[PWR_W-1:0];

  // Main sequencer: accumulate N samples, then C1 -> C2 -> C3 compute the
  // power and return to accumulating with cleared state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ACCUM;
      count       <= '0;
      s1          <= '0;
      s2          <= '0;
      c_reg       <= '0;
      t           <= '0;
      a           <= '0;
      power       <= '0;
      power_valid <= 1'b0;
      detect      <= 1'b0;
    end else begin
      power_valid <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            if (count == '0) begin
              c_reg <= coeff;
            end
            s2 <= s1;
            s1 <= s_next;
            if (count == CNT_W'(N - 1)) begin
              count <= '0;
              state <= ST_C1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        ST_C1: begin
          t     <= prod_q;
          state <= ST_C2;
        end
        ST_C2: begin
          a     <= a_next;
          state <= ST_C3;
        end
        ST_C3: begin
          power       <= p_clamped;
          detect      <= (p_clamped >= thresh);
          power_valid <= 1'b1;
          s1          <= '0;
          s2          <= '0;
          state       <= ST_ACCUM;
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_detector.sv
// tb_goertzel_detector
//   Directed bench for goertzel_detector. dut_a runs N=4 blocks with small
//   hand-worked sample patterns; dut_b (ACC_W=12, N=64) drives the state
//   registers into saturation.
module tb_goertzel_detector;

  logic clk;
  logic reset;

  logic signed [7:0]  sample_a;
  logic               valid_a;
  logic               ready_a;
  logic signed [15:0] coeff_a;
  logic [47:0]        thresh_a;
  logic [47:0]        power_a;
  logic               pv_a;
  logic               detect_a;

  logic signed [7:0]  sample_b;
  logic               valid_b;
  logic               ready_b;
  logic signed [15:0] coeff_b;
  logic [23:0]        thresh_b;
  logic [23:0]        power_b;
  logic               pv_b;
  logic               detect_b;

  int checks   = 0;
  int failures = 0;
  int pv_count_a = 0;
  int pv_count_b = 0;

  int exp_s1_a[4] = '{1, 0, -2, 0};
  int exp_s2_a[4] = '{0, 1, 0, -2};
  int exp_s1_b[5] = '{127, 380, 759, 1264, 1895};

  goertzel_detector #(
    .DATA_W (8), .N (4), .ACC_W (24), .COEFF_W (16), .PWR_W (48)
  ) dut_a (
    .clk (clk), .reset (reset), .in (sample_a), .in_valid (valid_a),
    .in_ready (ready_a), .coeff (coeff_a), .thresh (thresh_a),
    .power (power_a), .power_valid (pv_a), .detect (detect_a)
  );

  goertzel_detector #(
    .DATA_W (8), .N (64), .ACC_W (12), .COEFF_W (16), .PWR_W (24)
  ) dut_b (
    .clk (clk), .reset (reset), .in (sample_b), .in_valid (valid_b),
    .in_ready (ready_b), .coeff (coeff_b), .thresh (thresh_b),
    .power (power_b), .power_valid (pv_b), .detect (detect_b)
  );

  always #5 clk = ~clk;

  // Count result pulses on both detectors, sampled mid-cycle
  always @(negedge clk) begin
    if (pv_a) pv_count_a++;
    if (pv_b) pv_count_b++;
  end

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int value, input bit valid);
    sample_a = 8'(value);
    valid_a  = valid;
    tick();
  endtask

  task automatic feedBlock(input int v0, input int v1, input int v2, input int v3);
    applyStimulus(v0, 1'b1);
    applyStimulus(v1, 1'b1);
    applyStimulus(v2, 1'b1);
    applyStimulus(v3, 1'b1);
  endtask

  // Three compute cycles with in_valid held high; those samples must drop
  task automatic finishBlock(input string tag, input longint exp_power, input bit exp_detect);
    checkOutput({tag, "_c1_ready"}, longint'(ready_a), 0);
    applyStimulus(7, 1'b1);
    checkOutput({tag, "_c2_ready"}, longint'(ready_a), 0);
    checkOutput({tag, "_c2_pv"}, longint'(pv_a), 0);
    applyStimulus(7, 1'b1);
    checkOutput({tag, "_c3_ready"}, longint'(ready_a), 0);
    checkOutput({tag, "_c3_pv"}, longint'(pv_a), 0);
    applyStimulus(7, 1'b1);
    checkOutput({tag, "_pv"}, longint'(pv_a), 1);
    checkOutput({tag, "_power"}, longint'(power_a), exp_power);
    checkOutput({tag, "_detect"}, longint'(detect_a), longint'(exp_detect));
    checkOutput({tag, "_ready"}, longint'(ready_a), 1);
    sample_a = '0;
    valid_a  = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    sample_a = '0; valid_a = 1'b0; coeff_a = '0; thresh_a = 48'd4;
    sample_b = '0; valid_b = 1'b0; coeff_b = '0; thresh_b = 24'd0;
    tick();
    tick();
    checkOutput("rst_power", longint'(power_a), 0);
    checkOutput("rst_pv", longint'(pv_a), 0);
    checkOutput("rst_detect", longint'(detect_a), 0);
    checkOutput("rst_ready", longint'(ready_a), 1);
    checkOutput("rst_s1", longint'(dut_a.s1), 0);
    checkOutput("rst_s2", longint'(dut_a.s2), 0);
    reset = 1'b0;

    // 1,0,-1,0 with coeff 0: power 4, detect at thresh 4
    thresh_a = 48'd4;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(exp_s1_a[0] * ((i == 0) ? 1 : 0) + ((i == 2) ? -1 : 0), 1'b1);
      checkOutput($sformatf("blkA_s1_%0d", i), longint'(dut_a.s1), longint'(exp_s1_a[i]));
      checkOutput($sformatf("blkA_s2_%0d", i), longint'(dut_a.s2), longint'(exp_s2_a[i]));
    end
    finishBlock("blkA", 4, 1'b1);

    // DC input is rejected
    thresh_a = 48'd1;
    feedBlock(1, 1, 1, 1);
    finishBlock("dc", 0, 1'b0);

    // Same tone, higher threshold
    thresh_a = 48'd5;
    feedBlock(1, 0, -1, 0);
    checkOutput("blkB_s1", longint'(dut_a.s1), 0);
    checkOutput("blkB_s2", longint'(dut_a.s2), -2);
    finishBlock("blkB", 4, 1'b0);

    thresh_a = 48'd2;
    feedBlock(1, 0, -1, 0);
    finishBlock("blkC", 4, 1'b1);

    // Reset landing in the compute phase suppresses the result
    feedBlock(1, 0, -1, 0);
    checkOutput("abort_c1_ready", longint'(ready_a), 0);
    reset = 1'b1;
    applyStimulus(0, 1'b0);
    reset = 1'b0;
    checkOutput("abort_power", longint'(power_a), 0);
    checkOutput("abort_detect", longint'(detect_a), 0);
    checkOutput("abort_ready", longint'(ready_a), 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b0);
    checkOutput("abort_pv_count", longint'(pv_count_a), 4);

    // Reset after two accepted samples, then a clean block
    applyStimulus(1, 1'b1);
    applyStimulus(1, 1'b1);
    reset = 1'b1;
    applyStimulus(0, 1'b0);
    reset = 1'b0;
    checkOutput("midrst_s1", longint'(dut_a.s1), 0);
    checkOutput("midrst_pv_count", longint'(pv_count_a), 4);
    thresh_a = 48'd4;
    feedBlock(1, 0, -1, 0);
    finishBlock("postrst", 4, 1'b1);

    // coeff change after the first sample must not take effect
    coeff_a = 16'sd0;
    applyStimulus(1, 1'b1);
    coeff_a = 16'sd16384;
    applyStimulus(0, 1'b1);
    applyStimulus(-1, 1'b1);
    applyStimulus(0, 1'b1);
    finishBlock("latch", 4, 1'b1);

    // coeff = 1.0 from the start: s = (1,0),(1,1),(-1,1),(-2,-1); p = 5 - 2 = 3
    thresh_a = 48'd3;
    feedBlock(1, 0, -1, 0);
    finishBlock("c_one", 3, 1'b1);
    coeff_a = 16'sd0;
    applyStimulus(0, 1'b0);
    checkOutput("a_pv_count", longint'(pv_count_a), 7);

    // Saturation: ACC_W=12, c~2.0, in=127 -> s1 climbs to 2047 and stays
    coeff_b  = 16'sd32767;
    thresh_b = 24'd2047;
    for (int i = 0; i < 64; i++) begin
      sample_b = 8'sd127;
      valid_b  = 1'b1;
      tick();
      checkOutput($sformatf("sat_s1_%0d", i), longint'(dut_b.s1),
                  (i < 5) ? longint'(exp_s1_b[i]) : 2047);
    end
    valid_b = 1'b0;
    tick();
    checkOutput("sat_c2_pv", longint'(pv_b), 0);
    tick();
    checkOutput("sat_c3_pv", longint'(pv_b), 0);
    tick();
    // t = 4093, a = 2*2047^2 = 8380418, t*s2 = 8378371 -> p = 2047
    checkOutput("sat_pv", longint'(pv_b), 1);
    checkOutput("sat_power", longint'(power_b), 2047);
    checkOutput("sat_detect", longint'(detect_b), 1);
    tick();
    checkOutput("sat_pv_count", longint'(pv_count_b), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
